// File: rtl/conv_kernel_scheduler_if.sv
// conv_kernel_scheduler_if: window-source handshake, kernel controls and accumulator strobes
interface conv_kernel_scheduler_if #(
    parameter int WADDR_W = 4
);
    logic               win_valid;
    logic               win_ready;
    logic [WADDR_W-1:0] ic_sel;
    logic [WADDR_W-1:0] weight_addr;
    logic               bias_valid;
    logic               acc_clear;
    logic               acc_en;
    logic               ofm_valid;
    logic [WADDR_W-1:0] ofm_oc;

    modport master (
        input  win_valid,
        output win_ready, ic_sel, weight_addr, bias_valid,
        output acc_clear, acc_en, ofm_valid, ofm_oc
    );

    modport slave (
        output win_valid,
        input  win_ready, ic_sel, weight_addr, bias_valid,
        input  acc_clear, acc_en, ofm_valid, ofm_oc
    );
endinterface

// File: rtl/conv_kernel_scheduler.sv
// conv_kernel_scheduler: walks (pixel, out-group, in-group) beats and emits latency-aligned accumulator strobes
module conv_kernel_scheduler #(
    parameter int IC_GROUPS  = 2,
    parameter int OC_GROUPS  = 2,
    parameter int KERNEL_LAT = 2,
    parameter int WADDR_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [15:0]                   num_pixels,
    conv_kernel_scheduler_if.master       bus,
    output logic                          busy,
    output logic                          done
);
    localparam int DW = $clog2(KERNEL_LAT + 1);
    localparam int LW = WADDR_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t                       state, state_n;
    logic [WADDR_W-1:0]           ic_cnt, oc_cnt;
    logic [15:0]                  pix_cnt, np_q;
    logic [DW-1:0]                drain_cnt;
    logic [KERNEL_LAT-1:0][LW-1:0] dl;
    logic                         beat, ic_last, oc_last, pix_last, final_beat;
    logic                         first_d, last_d;

    // beat decode, kernel-side controls and delayed accumulator strobes
    always_comb begin
        ic_last          = ic_cnt == WADDR_W'(IC_GROUPS - 1);
        oc_last          = oc_cnt == WADDR_W'(OC_GROUPS - 1);
        pix_last         = pix_cnt == np_q - 16'd1;
        bus.win_ready    = state == S_RUN;
        beat             = bus.win_valid && bus.win_ready;
        final_beat       = beat && ic_last && oc_last && pix_last;
        bus.ic_sel       = ic_cnt;
        bus.weight_addr  = WADDR_W'(oc_cnt * WADDR_W'(IC_GROUPS) + ic_cnt);
        bus.bias_valid   = beat && ic_cnt == '0;
        {bus.acc_en, first_d, last_d, bus.ofm_oc} = dl[KERNEL_LAT-1];
        bus.acc_clear    = bus.acc_en && first_d;
        bus.ofm_valid    = bus.acc_en && last_d;
        busy             = state != S_IDLE;
        done             = state == S_FIN;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // next-state: an empty layer skips straight to the done pulse
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = num_pixels == 16'd0 ? S_FIN : S_RUN;
            S_RUN:   if (final_beat) state_n = S_DRAIN;
            S_DRAIN: if (drain_cnt == DW'(KERNEL_LAT - 1)) state_n = S_FIN;
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // nested group/pixel counters advance only on accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic_cnt    <= '0;
            oc_cnt    <= '0;
            pix_cnt   <= '0;
            np_q      <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                np_q    <= num_pixels;
                ic_cnt  <= '0;
                oc_cnt  <= '0;
                pix_cnt <= '0;
            end else if (beat) begin
                ic_cnt <= ic_last ? '0 : ic_cnt + 1'b1;
                if (ic_last) oc_cnt <= oc_last ? '0 : oc_cnt + 1'b1;
                if (ic_last && oc_last) pix_cnt <= pix_last ? '0 : pix_cnt + 16'd1;
            end
            drain_cnt <= state == S_DRAIN ? drain_cnt + 1'b1 : '0;
        end
    end

    // delay line matching the kernel latency so strobes line up with ofm data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl <= '0;
        end else begin
            dl[0] <= {beat, ic_cnt == '0, ic_last, oc_cnt};
            for (int i = 1; i < KERNEL_LAT; i++) dl[i] <= dl[i-1];
        end
    end
endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// tb_conv_kernel_scheduler: randomized layers checked against a beat-index reference model
module tb_conv_kernel_scheduler;
    localparam int ICG = 2;
    localparam int OCG = 2;
    localparam int K   = 2;
    localparam int AW  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_pixels = '0;
    logic        busy, done;
    int          n_cmp = 0;
    int          n_err = 0;

    conv_kernel_scheduler_if #(.WADDR_W(AW)) bus ();

    conv_kernel_scheduler #(
        .IC_GROUPS(ICG), .OC_GROUPS(OCG), .KERNEL_LAT(K), .WADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_pixels(num_pixels),
        .bus(bus.master), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, bus.win_ready, 0);
        check({tag, "_bias"}, bus.bias_valid, 0);
        check({tag, "_clear"}, bus.acc_clear, 0);
        check({tag, "_en"}, bus.acc_en, 0);
        check({tag, "_ofmv"}, bus.ofm_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_icsel"}, bus.ic_sel, 0);
        check({tag, "_waddr"}, bus.weight_addr, 0);
        check({tag, "_ofmoc"}, bus.ofm_oc, 0);
    endtask

    // mode 0: win_valid held high, 1: toggling, 2: random; poke re-pulses start mid-run
    task automatic run_layer(input int np, input int mode, input bit poke);
        int total, k, c, last_c, ofm_n, j, kk;
        bit vld, run_e, beat_e, en_e;
        bit bh[$];
        int kh[$];
        total = np * ICG * OCG;
        @(posedge clk); #1;
        start = 1'b1;
        num_pixels = 16'(np);
        bus.win_valid = 1'b0;
        @(negedge clk);
        check("pre_busy", busy, 0);
        check("pre_ready", bus.win_ready, 0);
        @(posedge clk); #1;
        start = 1'b0;
        if (np == 0) begin
            @(negedge clk);
            check("empty_busy", busy, 1);
            check("empty_done", done, 1);
            check("empty_ready", bus.win_ready, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check("empty_busy_off", busy, 0);
            check("empty_done_off", done, 0);
            return;
        end
        k = 0;
        last_c = -1;
        ofm_n = 0;
        for (c = 0; c < 5000; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            vld = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            bus.win_valid = vld;
            start = poke && c == 3;
            if (poke) num_pixels = 16'($urandom);
            @(negedge clk);
            run_e  = k < total;
            beat_e = run_e && vld;
            check("win_ready", bus.win_ready, run_e);
            check("busy", busy, run_e || (last_c >= 0 && c <= last_c + K + 1));
            check("done", done, last_c >= 0 && c == last_c + K + 1);
            check("bias_valid", bus.bias_valid, beat_e && k % ICG == 0);
            if (beat_e) begin
                check("weight_addr", bus.weight_addr, k % (ICG * OCG));
                check("ic_sel", bus.ic_sel, k % ICG);
            end
            bh.push_back(beat_e);
            kh.push_back(k);
            j    = c - K;
            en_e = j >= 0 ? bh[j] : 1'b0;
            kk   = j >= 0 ? kh[j] : 0;
            check("acc_en", bus.acc_en, en_e);
            check("acc_clear", bus.acc_clear, en_e && kk % ICG == 0);
            check("ofm_valid", bus.ofm_valid, en_e && kk % ICG == ICG - 1);
            check("ofm_oc", bus.ofm_oc, (kk / ICG) % OCG);
            ofm_n += int'(bus.ofm_valid);
            if (beat_e) begin
                k++;
                if (k == total) last_c = c;
            end
            if (last_c >= 0 && c == last_c + K + 2) break;
        end
        start = 1'b0;
        bus.win_valid = 1'b0;
        check("timeout", c < 5000, 1);
        check("ofm_count", ofm_n, np * OCG);
        repeat (K + 1) @(posedge clk);
    endtask

    initial begin
        bus.win_valid = 1'b0;
        #2;
        check_all_zero("reset");
        #11 rst_n = 1'b1;

        run_layer(3, 0, 1'b0);
        run_layer(1, 1, 1'b0);
        run_layer(0, 0, 1'b0);
        run_layer(2, 0, 1'b1);
        for (int t = 0; t < 4; t++) run_layer($urandom_range(1, 5), 2, t[0]);

        // reset during pixel 1 of 3
        @(posedge clk); #1;
        start = 1'b1;
        num_pixels = 16'd3;
        bus.win_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus.win_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
            check("midrst_idle", busy, 0);
        end
        run_layer(3, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
